// File: rtl/axi_read_master.sv
// AXI read initiator: accepts one local read command, issues the AR beat, buffers up to four R beats,
// then replays them to the requester with a burst-wide error flag.
module axi_read_master #(
    parameter int   BusWidth  = 32,
    parameter int   tagbits   = 2,
    parameter logic MASTER_ID = 1'b0
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [BusWidth-1:0] req_addr,
    input  logic [1:0]          req_len,
    input  logic [1:0]          req_size,
    input  logic [1:0]          req_burst,
    input  logic                req_id,
    output logic [tagbits-1:0]  ARID,
    output logic [BusWidth-1:0] ARADDR,
    output logic [3:0]          ARLEN,
    output logic [1:0]          ARSIZE,
    output logic [1:0]          ARBURST,
    output logic [1:0]          ARLOCK,
    output logic [3:0]          ARCACHE,
    output logic [2:0]          ARPROT,
    output logic                ARVALID,
    input  logic                ARREADY,
    input  logic [tagbits-1:0]  RID,
    input  logic [BusWidth-1:0] RDATA,
    input  logic [1:0]          RRESP,
    input  logic                RLAST,
    input  logic                RVALID,
    output logic                RREADY,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [BusWidth-1:0] resp_data,
    output logic                resp_last,
    output logic                resp_err,
    output logic                busy
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ADDR    = 2'd1;
    localparam logic [1:0] S_DATA    = 2'd2;
    localparam logic [1:0] S_DELIVER = 2'd3;

    logic [1:0]          r_state;
    logic [tagbits-1:0]  r_arid;
    logic [BusWidth-1:0] r_araddr;
    logic [1:0]          r_arlen;
    logic [1:0]          r_arsize;
    logic [1:0]          r_arburst;
    logic [BusWidth-1:0] r_buf [4];
    logic [2:0]          r_wr_cnt;
    logic [2:0]          r_rd_cnt;
    logic                r_err;

    logic [tagbits-1:0]  w_arid_next;
    logic                w_beat;
    logic                w_id_ok;
    logic                w_store;
    logic                w_full;
    logic                w_done;
    logic                w_empty;
    logic                w_last_beat;

    always_comb begin
        w_arid_next              = '0;
        w_arid_next[tagbits-1]   = MASTER_ID;
        w_arid_next[0]           = req_id;
    end

    assign w_beat      = RVALID && (r_state == S_DATA);
    assign w_id_ok     = (RID == r_arid);
    assign w_store     = w_beat && w_id_ok;
    // The stored beat about to land is beat number ARLEN+1.
    assign w_full      = w_store && (r_wr_cnt == {1'b0, r_arlen});
    assign w_done      = w_beat && (RLAST || w_full);
    assign w_empty     = (r_wr_cnt == 3'd0);
    assign w_last_beat = w_empty || (r_rd_cnt == r_wr_cnt - 3'd1);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state   <= S_IDLE;
            r_arid    <= '0;
            r_araddr  <= '0;
            r_arlen   <= '0;
            r_arsize  <= '0;
            r_arburst <= '0;
            r_wr_cnt  <= '0;
            r_rd_cnt  <= '0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_arid    <= w_arid_next;
                        r_araddr  <= req_addr;
                        r_arlen   <= req_len;
                        r_arsize  <= (req_size == 2'b11) ? 2'b10 : req_size;
                        r_arburst <= req_burst;
                        r_wr_cnt  <= '0;
                        r_rd_cnt  <= '0;
                        r_err     <= 1'b0;
                        r_state   <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (ARREADY) begin
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_beat) begin
                        if (w_store) begin
                            r_wr_cnt <= r_wr_cnt + 3'd1;
                        end
                        // Error on foreign ID, bad response, or RLAST disagreeing with the expected length.
                        if (!w_id_ok || (RRESP != 2'b00) || (RLAST != w_full)) begin
                            r_err <= 1'b1;
                        end
                        if (w_done) begin
                            r_state <= S_DELIVER;
                        end
                    end
                end
                default: begin
                    if (resp_ready) begin
                        if (w_last_beat) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_rd_cnt <= r_rd_cnt + 3'd1;
                        end
                    end
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_buf
            always_ff @(posedge ACLK or negedge ARESETn) begin
                if (!ARESETn) begin
                    r_buf[gi] <= '0;
                end else if (w_store && (r_wr_cnt[1:0] == 2'(gi))) begin
                    r_buf[gi] <= RDATA;
                end
            end
        end
    endgenerate

    assign req_ready  = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign ARVALID    = (r_state == S_ADDR);
    assign RREADY     = (r_state == S_DATA);
    assign resp_valid = (r_state == S_DELIVER);
    assign ARID       = r_arid;
    assign ARADDR     = r_araddr;
    assign ARLEN      = {2'b00, r_arlen};
    assign ARSIZE     = r_arsize;
    assign ARBURST    = r_arburst;
    assign ARLOCK     = 2'b00;
    assign ARCACHE    = 4'b0000;
    assign ARPROT     = 3'b000;
    // With every beat dropped, a single zero-data error beat is still handed back.
    assign resp_data  = (resp_valid && !w_empty) ? r_buf[r_rd_cnt[1:0]] : '0;
    assign resp_last  = resp_valid && w_last_beat;
    assign resp_err   = resp_valid && (r_err || w_empty);
endmodule
